// File: rtl/mult_seq_ctrl.sv
// Sequencer around a shift-and-add multiplier: valid/ready operand intake, start pulse,
// finish wait with watchdog, optional sign correction, and valid/ready result delivery.
module mult_seq_ctrl #(
  parameter int N       = 32,
  parameter bit SIGNED  = 1'b0,
  parameter int TIMEOUT = 4*N+16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_p,
  output logic           out_err,
  output logic           mul_start,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_o,
  input  logic           mul_finish,
  output logic [15:0]    op_count
);

  // state  | meaning
  // IDLE   | ready for an operand pair
  // LAUNCH | mul_start pulse
  // SETTLE | one cycle, stale mul_finish ignored
  // WAIT   | waiting for mul_finish, watchdog running
  // DONE   | result held until out_ready
  // ERR    | watchdog expired, terminal until reset
  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam int CW = $clog2(TIMEOUT+1);

  state_t          state, state_nxt;
  logic [CW-1:0]   tmo_cnt;
  logic [CW-1:0]   tmo_nxt;
  logic            neg;
  logic            neg_in;
  logic [N-1:0]    a_mag, b_mag;
  logic            accept, finish_hit, timeout_hit, handshake;

  assign in_ready    = (state == S_IDLE) && !out_err;
  assign accept      = in_ready && in_valid;
  assign tmo_nxt     = tmo_cnt + CW'(1);
  assign finish_hit  = (state == S_WAIT) && mul_finish;
  assign timeout_hit = (state == S_WAIT) && !mul_finish && (tmo_nxt == CW'(TIMEOUT));
  assign handshake   = (state == S_DONE) && out_valid && out_ready;

  // -2^(N-1) negates to itself, which reads correctly as an unsigned magnitude
  always_comb begin
    a_mag  = in_a;
    b_mag  = in_b;
    neg_in = 1'b0;
    if (SIGNED) begin
      a_mag  = in_a[N-1] ? -in_a : in_a;
      b_mag  = in_b[N-1] ? -in_b : in_b;
      neg_in = in_a[N-1] ^ in_b[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (mul_finish)       state_nxt = S_DONE;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_DONE:   if (handshake) state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_ERR;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      neg       <= 1'b0;
      tmo_cnt   <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      mul_start <= accept;
      if (accept) begin
        mul_a <= a_mag;
        mul_b <= b_mag;
        neg   <= neg_in;
      end
      if (state == S_SETTLE)    tmo_cnt <= '0;
      else if (state == S_WAIT) tmo_cnt <= tmo_nxt;
      if (finish_hit) begin
        out_p     <= neg ? -mul_o : mul_o;
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
      if (timeout_hit) out_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: an unsigned and a signed instance, each driven by a
// behavioural multiplier with programmable latency, checked against plain arithmetic.
module tb_mult_seq_ctrl;
  localparam int N   = 8;
  localparam int TMO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset      [2];
  logic           in_valid   [2];
  logic           in_ready   [2];
  logic [N-1:0]   in_a       [2];
  logic [N-1:0]   in_b       [2];
  logic           out_valid  [2];
  logic           out_ready  [2];
  logic [2*N-1:0] out_p      [2];
  logic           out_err    [2];
  logic           mul_start  [2];
  logic [N-1:0]   mul_a      [2];
  logic [N-1:0]   mul_b      [2];
  logic [2*N-1:0] mul_o      [2];
  logic           mul_finish [2];
  logic [15:0]    op_count   [2];

  int lat_cfg   [2];
  bit stale_cfg [2];
  int exp_cnt   [2];
  int vectors = 0;
  int errors  = 0;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    mult_seq_ctrl #(.N(N), .SIGNED(g), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_a(in_a[g]), .in_b(in_b[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_p(out_p[g]),
      .out_err(out_err[g]), .mul_start(mul_start[g]), .mul_a(mul_a[g]), .mul_b(mul_b[g]),
      .mul_o(mul_o[g]), .mul_finish(mul_finish[g]), .op_count(op_count[g])
    );

    // lat 0 = never finishes; stale keeps the old finish high through SETTLE
    logic           fin  = 1'b0;
    logic [2*N-1:0] mo   = '0;
    logic [N-1:0]   pa   = '0;
    logic [N-1:0]   pb   = '0;
    int             cnt  = 0;
    bit             keep = 1'b0;
    assign mul_finish[g] = fin;
    assign mul_o[g]      = mo;

    always @(posedge clk) begin
      if (mul_start[g]) begin
        cnt  <= lat_cfg[g];
        keep <= stale_cfg[g];
        pa   <= mul_a[g];
        pb   <= mul_b[g];
        if (!stale_cfg[g]) fin <= 1'b0;
      end else begin
        if (keep) begin
          keep <= 1'b0;
          fin  <= 1'b0;
        end
        if (cnt == 1) begin
          fin <= 1'b1;
          mo  <= 16'(pa) * 16'(pb);
        end
        if (cnt != 0) cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_reset(input int k);
    reset[k] = 1'b1;
    @(negedge clk);
    reset[k] = 1'b0;
    exp_cnt[k] = 0;
  endtask

  task automatic offer(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
    int cyc = 0;
    while (!in_ready[k] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("in_ready_wait", in_ready[k], 1);
    in_valid[k] = 1'b1;
    in_a[k] = a;
    in_b[k] = b;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_a[k] = 8'($urandom);
    in_b[k] = 8'($urandom);
  endtask

  // One full operation; with nxt set, the next pair is presented during the stall
  task automatic run_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int lat, input bit stale, input int stall,
                        input bit nxt, input logic [N-1:0] na, input logic [N-1:0] nb);
    int cyc, c_start, n_start, sa, sb;
    bit got;
    logic [2*N-1:0] exp_p;
    logic [N-1:0]   exp_ma, exp_mb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (k == 1) begin
      exp_p  = 16'(sa * sb);
      exp_ma = 8'(sa < 0 ? -sa : sa);
      exp_mb = 8'(sb < 0 ? -sb : sb);
    end else begin
      exp_p  = 16'(int'(a) * int'(b));
      exp_ma = a;
      exp_mb = b;
    end
    lat_cfg[k]   = lat;
    stale_cfg[k] = stale;
    out_ready[k] = (stall == 0);
    offer(k, a, b);
    cyc = 0; c_start = -1; n_start = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      if (mul_start[k]) begin
        n_start++;
        if (c_start < 0) begin
          c_start = cyc;
          chk("mul_a", mul_a[k], exp_ma);
          chk("mul_b", mul_b[k], exp_mb);
        end
      end
      if (out_valid[k]) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("out_valid_seen", got, 1);
    chk("start_at", c_start, 0);
    chk("start_pulses", n_start, 1);
    chk("latency", cyc, lat + 2);
    chk("out_p", out_p[k], exp_p);
    for (int i = 0; i < stall; i++) begin
      if (nxt) begin
        in_valid[k] = 1'b1;
        in_a[k] = na;
        in_b[k] = nb;
      end
      @(negedge clk);
      chk("stall_p", out_p[k], exp_p);
      chk("stall_valid", out_valid[k], 1);
      chk("stall_in_ready", in_ready[k], 0);
      chk("stall_no_start", mul_start[k], 0);
    end
    out_ready[k] = 1'b1;
    @(negedge clk);
    exp_cnt[k]++;
    chk("post_valid", out_valid[k], 0);
    chk("post_in_ready", in_ready[k], 1);
    chk("op_count", op_count[k], exp_cnt[k]);
  endtask

  task automatic abort_op(input int k, input bit in_done);
    int cyc = 0;
    lat_cfg[k]   = 10;
    stale_cfg[k] = 1'b0;
    out_ready[k] = 1'b0;
    offer(k, 8'($urandom), 8'($urandom));
    if (!in_done) repeat (4) @(negedge clk);
    else begin
      while (!out_valid[k] && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      chk("abort_reach_done", out_valid[k], 1);
    end
    pulse_reset(k);
    out_ready[k] = 1'b1;
    chk("abort_valid", out_valid[k], 0);
    chk("abort_in_ready", in_ready[k], 1);
    chk("abort_op_count", op_count[k], exp_cnt[k]);
    chk("abort_err", out_err[k], 0);
  endtask

  task automatic timeout_run(input int k);
    lat_cfg[k]   = 0;
    stale_cfg[k] = 1'b0;
    out_ready[k] = 1'b1;
    offer(k, 8'd5, 8'd9);
    chk("tmo_start", mul_start[k], 1);
    repeat (21) @(negedge clk);
    chk("tmo_err_early", out_err[k], 0);
    @(negedge clk);
    chk("tmo_err", out_err[k], 1);
    chk("tmo_in_ready", in_ready[k], 0);
    in_valid[k] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("err_hold", {out_err[k], in_ready[k], out_valid[k], mul_start[k]}, 4'b1000);
    end
    in_valid[k] = 1'b0;
    pulse_reset(k);
    chk("tmo_reset_err", out_err[k], 0);
    chk("tmo_reset_ready", in_ready[k], 1);
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] edge_v [4] = '{8'h80, 8'h7f, 8'h00, 8'hff};
    if ($urandom_range(0, 3) == 0) return edge_v[$urandom_range(0, 3)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [N-1:0] a2, b2;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      in_a[k] = '0; in_b[k] = '0; lat_cfg[k] = 4; stale_cfg[k] = 1'b0; exp_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", in_ready[k], 1);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_out_p", out_p[k], 0);
      chk("rst_out_err", out_err[k], 0);
      chk("rst_mul", {mul_start[k], mul_a[k], mul_b[k]}, 0);
      chk("rst_op_count", op_count[k], 0);
    end

    run_op(0, 8'd13, 8'd11, 4, 1'b0, 0, 1'b0, 8'd0, 8'd0);
    a2 = 8'($urandom); b2 = 8'($urandom);
    run_op(0, 8'd250, 8'd3, 5, 1'b0, 5, 1'b1, a2, b2);
    run_op(0, a2, b2, 3, 1'b0, 0, 1'b0, 8'd0, 8'd0);
    run_op(0, 8'd200, 8'd7, 6, 1'b1, 0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 12; i++)
      run_op(0, pick(), pick(), $urandom_range(2, 12), 1'($urandom), $urandom_range(0, 3),
             1'b0, 8'd0, 8'd0);

    abort_op(1, 1'b0);
    abort_op(1, 1'b1);
    run_op(1, 8'hFD, 8'd7, 4, 1'b0, 0, 1'b0, 8'd0, 8'd0);
    run_op(1, 8'h80, 8'h80, 2, 1'b1, 2, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 12; i++)
      run_op(1, pick(), pick(), $urandom_range(2, 12), 1'($urandom), $urandom_range(0, 3),
             1'b0, 8'd0, 8'd0);

    timeout_run(0);
    run_op(0, 8'd255, 8'd255, 7, 1'b0, 1, 1'b0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
